viterbi_traceback: RTL and testbench

- Survivor-path traceback unit of the Viterbi decoder. It sits after the add-compare-select stage and its survivor-memory writer.
- Each time a new survivor row is written, it walks back D-1 trellis steps through the circular survivor memory and emits one decoded bit.
- Survivor memory is external. This block drives a read address (time row, state column) and receives the selected survivor bit combinationally in the same cycle.

---
 rtl/viterbi_traceback_pkg.sv | 21 ++
 rtl/viterbi_traceback.sv | 121 ++++++++++++
 tb/tb_viterbi_traceback.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/viterbi_traceback_pkg.sv
// Shared Viterbi decoder constants, traceback FSM encoding and row-index helper.
package viterbi_traceback_pkg;

    localparam int K      = 3;
    localparam int M      = K - 1;
    localparam int S      = 1 << M;
    localparam int D      = 6;
    localparam int TIME_W = (D > 2) ? $clog2(D) : 1;

    typedef enum logic [1:0] {
        IDLE,
        TRACE,
        DECODE
    } fsm_state_t;

    // Circular decrement of a survivor-memory row index: 0 wraps to depth-1.
    function automatic int unsigned wrap_dec(input int unsigned t, input int unsigned depth);
        return (t == 0) ? depth - 1 : t - 1;
    endfunction

endpackage

// File: rtl/viterbi_traceback.sv
// Survivor-path traceback: walks D-1 steps back from the newest row and emits one decoded bit.
module viterbi_traceback #(
    parameter  int M      = 2,
    parameter  int D      = 6,
    localparam int TIME_W = (D > 2) ? $clog2(D) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [TIME_W-1:0] wr_ptr,
    input  logic [M-1:0]      s_end,
    input  logic              force_state0,
    output logic [TIME_W-1:0] tb_time,
    output logic [M-1:0]      tb_state,
    input  logic              tb_surv_bit,
    output logic              dec_bit_valid,
    output logic              dec_bit
);

    import viterbi_traceback_pkg::*;

    localparam int FW = $clog2(D + 1);

    fsm_state_t        state, state_n;
    logic [TIME_W-1:0] wr_ptr_q;
    logic [FW-1:0]     fill_cnt, fill_n;
    logic [TIME_W-1:0] step_cnt, step_n;
    logic              pending, pend_n;
    logic [TIME_W-1:0] time_n;
    logic [M-1:0]      st_n;
    logic              dec_n, valid_n;

    logic              new_row;
    logic [TIME_W-1:0] start_time;
    logic [M-1:0]      start_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        new_row     = (wr_ptr != wr_ptr_q);
        start_time  = TIME_W'(wrap_dec(32'(wr_ptr), D));
        start_state = force_state0 ? '0 : s_end;

        state_n = state;
        time_n  = tb_time;
        st_n    = tb_state;
        step_n  = step_cnt;
        pend_n  = pending;
        dec_n   = dec_bit;
        valid_n = 1'b0;
        fill_n  = (new_row && fill_cnt != FW'(D)) ? fill_cnt + FW'(1) : fill_cnt;

        case (state)
            IDLE: begin
                if (new_row && fill_cnt >= FW'(D - 1)) begin
                    time_n  = start_time;
                    st_n    = start_state;
                    step_n  = '0;
                    pend_n  = 1'b0;
                    state_n = TRACE;
                end
            end
            TRACE: begin
                if (new_row) begin
                    pend_n = 1'b1;
                end
                st_n   = {tb_state[M-2:0], tb_surv_bit};
                time_n = TIME_W'(wrap_dec(32'(tb_time), D));
                step_n = step_cnt + TIME_W'(1);
                if (step_cnt == TIME_W'(D - 2)) begin
                    state_n = DECODE;
                end
            end
            DECODE: begin
                dec_n   = tb_state[M-1];
                valid_n = 1'b1;
                // A row landing on this very edge is folded into the pending restart.
                if (pending || new_row) begin
                    time_n  = start_time;
                    st_n    = start_state;
                    step_n  = '0;
                    pend_n  = 1'b0;
                    state_n = TRACE;
                end else begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q      <= '0;
            fill_cnt      <= '0;
            step_cnt      <= '0;
            pending       <= 1'b0;
            tb_time       <= '0;
            tb_state      <= '0;
            dec_bit       <= 1'b0;
            dec_bit_valid <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr;
            fill_cnt      <= fill_n;
            step_cnt      <= step_n;
            pending       <= pend_n;
            tb_time       <= time_n;
            tb_state      <= st_n;
            dec_bit       <= dec_n;
            dec_bit_valid <= valid_n;
        end
    end

endmodule

// File: tb/tb_viterbi_traceback.sv
// Directed bench for viterbi_traceback with a behavioural survivor memory and decoded-bit scoreboard.
module tb_viterbi_traceback;

    localparam int M  = 2;
    localparam int D  = 6;
    localparam int S  = 1 << M;
    localparam int TW = 3;

    logic          clk;
    logic          rst_n;
    logic [TW-1:0] wr_ptr;
    logic [M-1:0]  s_end;
    logic          force_state0;
    logic [TW-1:0] tb_time;
    logic [M-1:0]  tb_state;
    logic          tb_surv_bit;
    logic          dec_bit_valid;
    logic          dec_bit;

    logic [S-1:0]  mem [D];
    bit            q_exp[$];
    int            checks  = 0;
    int            errors  = 0;
    int            strobes = 0;
    int            rows    = 0;

    viterbi_traceback #(.M(M), .D(D)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .wr_ptr        (wr_ptr),
        .s_end         (s_end),
        .force_state0  (force_state0),
        .tb_time       (tb_time),
        .tb_state      (tb_state),
        .tb_surv_bit   (tb_surv_bit),
        .dec_bit_valid (dec_bit_valid),
        .dec_bit       (dec_bit)
    );

    assign tb_surv_bit = mem[tb_time][tb_state];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int prev_row(input int t);
        return (t + D - 1) % D;
    endfunction

    function automatic bit model(input int newest, input logic [M-1:0] st0);
        logic [M-1:0] st = st0;
        int           t  = newest;
        for (int i = 0; i < D - 1; i++) begin
            st = {st[M-2:0], mem[t][st]};
            t  = prev_row(t);
        end
        return st[M-1];
    endfunction

    always @(negedge clk) begin
        if (rst_n && dec_bit_valid) begin
            strobes++;
            chk("strobe_expected", 32'(q_exp.size() != 0), 32'd1);
            if (q_exp.size() != 0) begin
                chk("dec_bit", 32'(dec_bit), 32'(q_exp.pop_front()));
            end
        end
    end

    function automatic logic [TW-1:0] next_ptr(input logic [TW-1:0] p);
        return (p == TW'(D - 1)) ? '0 : p + TW'(1);
    endfunction

    // Called at a negedge; consumes D+3 cycles and checks the read-address walk.
    task automatic write_row(input logic [S-1:0] row, input logic [M-1:0] se, input logic f);
        int           newest;
        int           t;
        logic [M-1:0] st;
        newest       = int'(wr_ptr);
        mem[wr_ptr]  = row;
        s_end        = se;
        force_state0 = f;
        wr_ptr       = next_ptr(wr_ptr);
        rows++;
        if (rows >= D) begin
            st = f ? '0 : se;
            t  = newest;
            q_exp.push_back(model(newest, st));
            @(posedge clk);
            @(negedge clk);
            chk("start_time", 32'(tb_time), 32'(t));
            chk("start_state", 32'(tb_state), 32'(st));
            for (int i = 0; i < D - 1; i++) begin
                st = {st[M-2:0], mem[t][st]};
                t  = prev_row(t);
                @(negedge clk);
                chk("step_time", 32'(tb_time), 32'(t));
                chk("step_state", 32'(tb_state), 32'(st));
            end
            repeat (3) @(negedge clk);
        end else begin
            repeat (D + 3) @(negedge clk);
        end
    endtask

    initial begin
        int           na, nb;
        logic [M-1:0] sb;

        rst_n        = 1'b0;
        wr_ptr       = '0;
        s_end        = '0;
        force_state0 = 1'b0;
        for (int i = 0; i < D; i++) mem[i] = '0;
        #1;
        chk("reset_time", 32'(tb_time), 32'd0);
        chk("reset_state", 32'(tb_state), 32'd0);
        chk("reset_valid", 32'(dec_bit_valid), 32'd0);
        chk("reset_dec", 32'(dec_bit), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill: first D-1 rows silent, then one strobe per row.
        for (int i = 0; i < 50; i++) begin
            write_row(S'($urandom), M'($urandom), 1'($urandom));
            if (i == D - 2) chk("no_strobe_before_fill", 32'(strobes), 32'd0);
            if (i == D - 1) chk("first_strobe", 32'(strobes), 32'd1);
        end
        chk("strobe_count_50", 32'(strobes), 32'd45);

        for (int i = 0; i < D; i++) write_row('0, 2'b11, 1'b1);
        for (int i = 0; i < D; i++) write_row('1, 2'b10, 1'b1);
        for (int i = 0; i < D; i++) write_row('0, 2'b10, 1'b0);
        while (wr_ptr != TW'(D - 1)) write_row(S'($urandom), M'($urandom), 1'b0);
        write_row(4'b0110, 2'b01, 1'b0);
        chk("wrap_ptr", 32'(wr_ptr), 32'd0);
        write_row(4'b1010, 2'b11, 1'b0);

        // Two rows close together: second one is held as pending and restarts from DECODE.
        na           = int'(wr_ptr);
        mem[wr_ptr]  = 4'b1001;
        s_end        = 2'b11;
        force_state0 = 1'b0;
        wr_ptr       = next_ptr(wr_ptr);
        rows++;
        q_exp.push_back(model(na, 2'b11));
        repeat (2) @(negedge clk);
        nb           = int'(wr_ptr);
        mem[wr_ptr]  = 4'b0101;
        sb           = 2'b01;
        s_end        = sb;
        wr_ptr       = next_ptr(wr_ptr);
        rows++;
        q_exp.push_back(model(nb, sb));
        repeat (5) @(negedge clk);
        chk("pending_restart_time", 32'(tb_time), 32'(nb));
        chk("pending_restart_state", 32'(tb_state), 32'(sb));
        repeat (2 * (D + 3)) @(negedge clk);
        chk("pending_drained", 32'(q_exp.size()), 32'd0);

        // Reset in the middle of a traceback: no strobe, refill required.
        mem[wr_ptr] = 4'b1111;
        wr_ptr      = next_ptr(wr_ptr);
        repeat (3) @(negedge clk);
        #2;
        rst_n  = 1'b0;
        wr_ptr = '0;
        #1;
        chk("midreset_time", 32'(tb_time), 32'd0);
        chk("midreset_state", 32'(tb_state), 32'd0);
        chk("midreset_valid", 32'(dec_bit_valid), 32'd0);
        chk("midreset_dec", 32'(dec_bit), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rows  = 0;
        strobes = 0;
        repeat (D + 3) @(negedge clk);
        chk("no_strobe_after_reset", 32'(strobes), 32'd0);
        for (int i = 0; i < D; i++) begin
            write_row(S'($urandom), M'($urandom), 1'b0);
            if (i == D - 2) chk("refill_silent", 32'(strobes), 32'd0);
        end
        chk("refill_strobe", 32'(strobes), 32'd1);
        chk("queue_empty", 32'(q_exp.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
